zigzag_rle_encoder: RTL and testbench



---
 rtl/zigzag_rle_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_zigzag_rle_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder
//   Buffers one 8x8 block of quantized coefficients (raster order), then
//   walks it in JPEG zigzag order and emits (run, level) tokens followed by
//   an end-of-block token for the entropy coder.
//
//   Parameters:
//     COEF_W  width of a signed coefficient / token level
//     RUN_W   width of the zero-run count (>= 6)
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready/in_coef  coefficient input stream (raster order)
//     out_valid/out_ready        token output handshake
//     out_run, out_level         zero run preceding level, signed level
//     out_eob                    token is end-of-block (run=0, level=0)
//     block_done                 one-cycle pulse after the EOB token is taken
//
//   Build option: define ZZ_PINGPONG_EN for a two-bank buffer so that loading
//   the next block overlaps the scan of the current one.
module zigzag_rle_encoder #(
  parameter int COEF_W = 12,
  parameter int RUN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [COEF_W-1:0] out_level,
  output logic              out_eob,
  output logic              block_done
);

`ifdef ZZ_PINGPONG_EN
  localparam int AW = 7;
`else
  localparam int AW = 6;
`endif

  // Zigzag ROM: entry i (LSB first) is the raster address of scan index i.
  localparam logic [383:0] ZZ_TABLE = {
    6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58,
    6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd15, 6'd22, 6'd29,
    6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
    6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
    6'd5,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd2,  6'd9,  6'd16, 6'd8,  6'd1,  6'd0
  };

  typedef enum logic [1:0] {S_LOAD, S_SCAN, S_EOB} state_t;

  state_t              r_state;
  logic [5:0]          r_wr_cnt;
  logic [5:0]          r_scan_idx;
  logic [5:0]          r_rd_idx;
  logic                r_rd_vld;
  logic [COEF_W-1:0]   r_rd_coef;
  logic [RUN_W-1:0]    r_run_cnt;
  logic                r_out_valid;
  logic [RUN_W-1:0]    r_out_run;
  logic [COEF_W-1:0]   r_out_level;
  logic                r_out_eob;
  logic                r_block_done;
  logic [COEF_W-1:0]   r_mem [0:(2**AW)-1];

  logic                w_wr_en;
  logic                w_wr_last;
  logic                w_out_free;
  logic                w_issue;
  logic                w_eob_acc;
  logic                w_bank_ready;
  logic [5:0]          w_zz;
  logic [AW-1:0]       w_wr_addr;
  logic [AW-1:0]       w_rd_addr;

  assign w_wr_en    = in_valid && in_ready;
  assign w_wr_last  = w_wr_en && (r_wr_cnt == 6'd63);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_eob_acc  = r_out_valid && r_out_eob && out_ready;
  assign w_zz       = ZZ_TABLE[int'(r_scan_idx)*6 +: 6];
  // Stop issuing reads once index 63 sits in the read stage.
  assign w_issue    = (r_state == S_SCAN) && w_out_free &&
                      !(r_rd_vld && (r_rd_idx == 6'd63));

`ifdef ZZ_PINGPONG_EN
  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;

  assign in_ready     = !r_full[r_wr_bank];
  assign w_wr_addr    = {r_wr_bank, r_wr_cnt};
  assign w_rd_addr    = {r_rd_bank, w_zz};
  assign w_bank_ready = r_full[r_rd_bank] || (w_wr_last && (r_wr_bank == r_rd_bank));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_eob_acc) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
    end
  end
`else
  logic r_full;

  assign in_ready     = !r_full;
  assign w_wr_addr    = r_wr_cnt;
  assign w_rd_addr    = w_zz;
  assign w_bank_ready = r_full || w_wr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else begin
      if (w_eob_acc) r_full <= 1'b0;
      if (w_wr_last) r_full <= 1'b1;
    end
  end
`endif

  // Coefficient storage with a registered read port (one-cycle read stage).
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= in_coef;
    if (w_issue) r_rd_coef <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_wr_cnt     <= 6'd0;
      r_scan_idx   <= 6'd0;
      r_rd_idx     <= 6'd0;
      r_rd_vld     <= 1'b0;
      r_run_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_run    <= '0;
      r_out_level  <= '0;
      r_out_eob    <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 6'd1;

      case (r_state)
        S_LOAD: begin
          if (w_bank_ready) begin
            r_state    <= S_SCAN;
            r_scan_idx <= 6'd0;
            r_rd_vld   <= 1'b0;
            r_run_cnt  <= '0;
          end
        end

        S_SCAN: begin
          if (w_out_free) begin
            r_out_valid <= 1'b0;
            if (r_rd_vld) begin
              // DC is always emitted; AC zeros only extend the run.
              if ((r_rd_idx == 6'd0) || (r_rd_coef != '0)) begin
                r_out_valid <= 1'b1;
                r_out_run   <= r_run_cnt;
                r_out_level <= r_rd_coef;
                r_out_eob   <= 1'b0;
                r_run_cnt   <= '0;
              end else begin
                r_run_cnt <= r_run_cnt + RUN_W'(1);
              end
              // Trailing zeros are dropped: clear the run at the last index.
              if (r_rd_idx == 6'd63) begin
                r_state   <= S_EOB;
                r_run_cnt <= '0;
              end
            end
            if (w_issue) begin
              r_rd_vld   <= 1'b1;
              r_rd_idx   <= r_scan_idx;
              r_scan_idx <= r_scan_idx + 6'd1;
            end else begin
              r_rd_vld <= 1'b0;
            end
          end
        end

        S_EOB: begin
          if (w_eob_acc) begin
            r_out_valid  <= 1'b0;
            r_out_eob    <= 1'b0;
            r_block_done <= 1'b1;
            r_state      <= S_LOAD;
          end else if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_run   <= '0;
            r_out_level <= '0;
            r_out_eob   <= 1'b1;
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_run    = r_out_run;
  assign out_level  = r_out_level;
  assign out_eob    = r_out_eob;
  assign block_done = r_block_done;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
module tb_zigzag_rle_encoder;
  localparam int CW = 12;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_coef = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_run;
  logic [CW-1:0] out_level;
  logic          out_eob;
  logic          block_done;

  always #5 clk = ~clk;

  zigzag_rle_encoder #(.COEF_W(CW), .RUN_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_level (out_level),
    .out_eob   (out_eob),
    .block_done(block_done)
  );

  // Sparse block: up to two nonzero raster positions, out_ready pattern,
  // and the hand-computed data tokens (EOB is appended by the bench).
  typedef struct {
    int nnz;
    int a0, v0, a1, v1;
    int mode;
    int ntok;
    int r0, l0, r1, l1, r2, l2;
  } vec_t;

  vec_t          vecs [5];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] blk  [64];
  logic [CW-1:0] blk2 [64];
  int            zz   [64];
  int            q_run[$], q_lvl[$], q_eob[$];
  int            e_run[$], e_lvl[$], e_eob[$];
  int            done_cnt;
  int            first_valid;

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int r, input int l, input int e);
    e_run.push_back(r);
    e_lvl.push_back(l);
    e_eob.push_back(e);
  endtask

  // Reference encoder: zigzag reorder then run-length code.
  task automatic model_block(input int which);
    int run;
    int v;
    run = 0;
    for (int i = 0; i < 64; i++) begin
      v = (which == 0) ? int'($signed(blk[zz[i]])) : int'($signed(blk2[zz[i]]));
      if (i == 0) push_exp(0, v, 0);
      else if (v != 0) begin
        push_exp(run, v, 0);
        run = 0;
      end else run++;
    end
    push_exp(0, 0, 1);
  endtask

  task automatic send_block();
    int guard;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_coef  = blk[i];
      guard    = 0;
      while (!in_ready && guard < 300) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 300) check("in_ready timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Collects tokens until n_eob EOBs or max_tok tokens; checks hold-stability.
  task automatic collect(input int mode, input int max_tok, input int n_eob);
    logic          rdy, sv, se, hold_prev;
    logic [RW-1:0] sr;
    logic [CW-1:0] sl;
    longint        prev_vec;
    int            eobs;
    bit            finished;
    q_run.delete(); q_lvl.delete(); q_eob.delete();
    done_cnt = 0; first_valid = -1; eobs = 0; finished = 0;
    hold_prev = 1'b0; prev_vec = 0;
    for (int k = 0; k < 3000; k++) begin
      if (out_valid && first_valid < 0) first_valid = k;
      if (hold_prev)
        check("hold", longint'({out_valid, out_run, out_level, out_eob}), prev_vec);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = ((k % 3) != 0);
      endcase
      out_ready = rdy;
      sv = out_valid; sr = out_run; sl = out_level; se = out_eob;
      hold_prev = sv && !rdy;
      prev_vec  = longint'({sv, sr, sl, se});
      @(posedge clk); #1;
      if (block_done) done_cnt++;
      if (sv && rdy) begin
        q_run.push_back(int'(sr));
        q_lvl.push_back(int'($signed(sl)));
        q_eob.push_back(int'(se));
        if (se) eobs++;
      end
      if (eobs == n_eob || q_run.size() == max_tok) begin
        finished = 1;
        break;
      end
    end
    out_ready = 1'b0;
    check("collect finished", finished, 1);
  endtask

  task automatic compare_tokens(input string tag);
    check({tag, " token count"}, q_run.size(), e_run.size());
    for (int i = 0; i < q_run.size() && i < e_run.size(); i++) begin
      check($sformatf("%s tok%0d run", tag, i), q_run[i], e_run[i]);
      check($sformatf("%s tok%0d level", tag, i), q_lvl[i], e_lvl[i]);
      check($sformatf("%s tok%0d eob", tag, i), q_eob[i], e_eob[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_run"}, out_run, 0);
    check({tag, " out_level"}, out_level, 0);
    check({tag, " out_eob"}, out_eob, 0);
    check({tag, " block_done"}, block_done, 0);
  endtask

  initial begin
    int n;
    int stalls;
    int guard;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{2, 0, -5, 63, 7, 0, 2, 0, -5, 62, 7, 0, 0};
    vecs[2] = '{2, 1, 3, 8, -2, 1, 3, 0, 0, 0, 3, 0, -2};
    vecs[3] = '{2, 9, -1, 2, 4, 2, 3, 0, 0, 3, -1, 0, 4};
    vecs[4] = '{2, 0, 2047, 56, -2048, 1, 2, 0, 2047, 34, -2048, 0, 0};

    // Zigzag order by walking anti-diagonals, alternating direction.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[n] = r * 8 + (s - r); n++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[n] = r * 8 + (s - r); n++;
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 64; i++) blk[i] = '0;
      if (vecs[v].nnz > 0) blk[vecs[v].a0] = CW'(vecs[v].v0);
      if (vecs[v].nnz > 1) blk[vecs[v].a1] = CW'(vecs[v].v1);
      e_run.delete(); e_lvl.delete(); e_eob.delete();
      push_exp(vecs[v].r0, vecs[v].l0, 0);
      if (vecs[v].ntok > 1) push_exp(vecs[v].r1, vecs[v].l1, 0);
      if (vecs[v].ntok > 2) push_exp(vecs[v].r2, vecs[v].l2, 0);
      push_exp(0, 0, 1);
      send_block();
      collect(vecs[v].mode, 1000, 1);
      compare_tokens($sformatf("vec%0d", v));
      check($sformatf("vec%0d first-token latency", v), first_valid, 2);
      check($sformatf("vec%0d block_done pulses", v), done_cnt, 1);
      check($sformatf("vec%0d in_ready after EOB", v), in_ready, 1);
      $display("vec%0d: %0d tokens, latency %0d", v, q_run.size(), first_valid);
    end

    // Dense block: every coefficient nonzero -> 64 data tokens + EOB.
    for (int i = 0; i < 64; i++) blk[i] = CW'(i + 1);
    e_run.delete(); e_lvl.delete(); e_eob.delete();
    model_block(0);
    send_block();
    collect(0, 1000, 1);
    check("dense total tokens", q_run.size(), 65);
    compare_tokens("dense");
    check("dense block_done pulses", done_cnt, 1);
    $display("dense: %0d tokens", q_run.size());

    // Reset in the middle of a scan, then a clean block.
    send_block();
    collect(0, 10, 1);
    check("pre-reset tokens", q_run.size(), 10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-scan reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block();
    collect(2, 1000, 1);
    compare_tokens("post-reset");
    check("post-reset block_done pulses", done_cnt, 1);
    $display("post-reset: %0d tokens", q_run.size());

`ifdef ZZ_PINGPONG_EN
    for (int i = 0; i < 64; i++) blk2[i] = '0;
    blk2[5] = CW'(-9);
    e_run.delete(); e_lvl.delete(); e_eob.delete();
    model_block(0);
    model_block(1);
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 128; i++) begin
          in_valid = 1'b1;
          in_coef  = (i < 64) ? blk[i] : blk2[i - 64];
          guard    = 0;
          while (!in_ready && guard < 300) begin
            stalls++;
            @(posedge clk); #1;
            guard++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        collect(0, 1000, 2);
      end
    join
    check("pingpong in_ready stalls", stalls, 0);
    check("pingpong block_done pulses", done_cnt, 2);
    compare_tokens("pingpong");
    $display("pingpong: %0d tokens, %0d stalls", q_run.size(), stalls);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
